mem_bist_seq: RTL and testbench

//  Synthesizable write/read-back sequencer for the single-port data memory.

---
 rtl/mem_bist_seq.sv | 150 +++++++++++++++
 tb/tb_mem_bist_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_seq.sv
// rtl/mem_bist_seq.sv - write/read-back memory test sequencer with pass/fail status
module mem_bist_seq #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              rd_only,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_read,
    output logic              mem_write,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              rd_mismatch;

    // Expected memory contents for a given pattern and address.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        case (m)
            2'b00:   p = DATA_W'(a);
            2'b01:   p = a[0] ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
            2'b10:   p = ~DATA_W'(a);
            default: p = '1;
        endcase
        return p;
    endfunction

    // Compare the returned read data against the pattern for the current slot.
    always_comb begin
        rd_mismatch = (mem_data_out != pattern(mode_q, mem_addr));
    end

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            mode_q          <= 2'b00;
            lat_cnt         <= '0;
            mem_addr        <= '0;
            mem_data_in     <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (start) begin
                        mode_q          <= mode;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        mem_addr        <= '0;
                        lat_cnt         <= '0;
                        if (rd_only) begin
                            state    <= S_READ;
                            mem_read <= 1'b1;
                        end else begin
                            state       <= S_WRITE;
                            mem_write   <= 1'b1;
                            mem_data_in <= pattern(mode, '0);
                        end
                    end
                end

                S_WRITE: begin
                    if (mem_addr == ADDR_LAST) begin
                        state       <= S_READ;
                        mem_write   <= 1'b0;
                        mem_data_in <= '0;
                        mem_read    <= 1'b1;
                        mem_addr    <= '0;
                        lat_cnt     <= '0;
                    end else begin
                        mem_addr    <= mem_addr + ADDR_W'(1);
                        mem_data_in <= pattern(mode_q, mem_addr + ADDR_W'(1));
                    end
                end

                S_READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt <= '0;
                        if (rd_mismatch) begin
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_addr  <= mem_addr;
                            end
                        end
                        if (mem_addr == ADDR_LAST) begin
                            state    <= S_DONE;
                            mem_read <= 1'b0;
                            mem_addr <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            // Fold in the final slot's result so pass is valid with done.
                            pass     <= !(first_err_valid || rd_mismatch);
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_seq.sv
// tb/tb_mem_bist_seq.sv - scoreboard bench for mem_bist_seq across three parameter sets
module tb_mem_bist_seq;

    typedef struct {
        int inst;
        int t0;
        int n;
        int pass;
        int err;
        int fev;
        int fea;
        int wr;
        int rd;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    exp_t       exp_q[$];

    logic       rst_n [3];
    logic       start [3];
    logic [1:0] mode [3];
    logic       rd_only [3];
    logic [4:0] mem_addr [3];
    logic [7:0] mem_data_in [3];
    logic [7:0] mem_data_out [3];
    logic       mem_read [3];
    logic       mem_write [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic       first_err_valid [3];
    logic [4:0] first_err_addr [3];
    logic [15:0] err_a;
    logic [15:0] err_b;
    logic [3:0]  err_c;
    logic       stuck_en = 1'b0;
    int         wr_cnt [3];
    int         rd_cnt [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bist_seq u_a (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .mode(mode[0]), .rd_only(rd_only[0]),
        .mem_addr(mem_addr[0]), .mem_data_in(mem_data_in[0]), .mem_data_out(mem_data_out[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err_a), .first_err_valid(first_err_valid[0]),
        .first_err_addr(first_err_addr[0])
    );

    mem_bist_seq #(.RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .mode(mode[1]), .rd_only(rd_only[1]),
        .mem_addr(mem_addr[1]), .mem_data_in(mem_data_in[1]), .mem_data_out(mem_data_out[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err_b), .first_err_valid(first_err_valid[1]),
        .first_err_addr(first_err_addr[1])
    );

    mem_bist_seq #(.ERR_W(4)) u_c (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .mode(mode[2]), .rd_only(rd_only[2]),
        .mem_addr(mem_addr[2]), .mem_data_in(mem_data_in[2]), .mem_data_out(mem_data_out[2]),
        .mem_read(mem_read[2]), .mem_write(mem_write[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_count(err_c), .first_err_valid(first_err_valid[2]),
        .first_err_addr(first_err_addr[2])
    );

    // Memory models: array plus a read pipeline of depth LAT (1, 3, 1).
    for (genvar g = 0; g < 3; g++) begin : g_mem
        localparam int LAT = (g == 1) ? 3 : 1;
        logic [7:0] mem [32];
        logic [7:0] pipe [4];
        logic [7:0] rdval;
        initial begin
            for (int j = 0; j < 32; j++) mem[j] = 8'h00;
            for (int j = 0; j < 4; j++) pipe[j] = 8'h00;
        end
        // Bit 1 is used for the stuck-at-1 fault because bit 0 of 0x55 is already 1.
        assign rdval = mem[mem_addr[g]] |
                       ((g == 0 && stuck_en && mem_addr[g] == 5'd6) ? 8'h02 : 8'h00);
        always @(posedge clk) begin
            if (mem_write[g]) mem[mem_addr[g]] <= mem_data_in[g];
            pipe[0] <= rdval;
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign mem_data_out[g] = pipe[LAT-1];
    end

    function automatic int errv(input int i);
        case (i)
            0:       return int'(err_a);
            1:       return int'(err_b);
            default: return int'(err_c);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: per-cycle port invariants and scoreboard pop on each done pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("rw_exclusive", int'(mem_read[i] && mem_write[i]), 0);
            if (!mem_write[i]) chk("din_zero_outside_write", int'(mem_data_in[i]), 0);
            if (!mem_write[i] && !mem_read[i]) chk("addr_zero_idle", int'(mem_addr[i]), 0);
            if (done[i]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t r;
                    r = exp_q.pop_front();
                    chk("done_inst", i, r.inst);
                    chk("done_cycle", cyc - r.t0, r.n);
                    chk("pass", int'(pass[i]), r.pass);
                    chk("err_count", errv(i), r.err);
                    chk("first_err_valid", int'(first_err_valid[i]), r.fev);
                    chk("first_err_addr", int'(first_err_addr[i]), r.fea);
                    chk("busy_at_done", int'(busy[i]), 0);
                    chk("write_cycles", wr_cnt[i], r.wr);
                    chk("read_cycles", rd_cnt[i], r.rd);
                end
                wr_cnt[i] = 0;
                rd_cnt[i] = 0;
            end else if (!rst_n[i]) begin
                wr_cnt[i] = 0;
                rd_cnt[i] = 0;
            end else begin
                if (mem_write[i]) wr_cnt[i]++;
                if (mem_read[i]) rd_cnt[i]++;
            end
        end
    end

    task automatic check_zero(input int i, input string tag);
        chk({tag, "_addr"}, int'(mem_addr[i]), 0);
        chk({tag, "_din"}, int'(mem_data_in[i]), 0);
        chk({tag, "_rd"}, int'(mem_read[i]), 0);
        chk({tag, "_wr"}, int'(mem_write[i]), 0);
        chk({tag, "_busy"}, int'(busy[i]), 0);
        chk({tag, "_done"}, int'(done[i]), 0);
        chk({tag, "_pass"}, int'(pass[i]), 0);
        chk({tag, "_err"}, errv(i), 0);
        chk({tag, "_fev"}, int'(first_err_valid[i]), 0);
        chk({tag, "_fea"}, int'(first_err_addr[i]), 0);
    endtask

    task automatic do_run(input int i, input logic [1:0] m, input logic ro, input int n,
                          input int p, input int e, input int fev, input int fea,
                          input int wr, input int rd, input bit pulses);
        exp_t r;
        bit seen;
        @(negedge clk);
        start[i] = 1'b1;
        mode[i] = m;
        rd_only[i] = ro;
        r.inst = i; r.t0 = cyc; r.n = n; r.pass = p; r.err = e;
        r.fev = fev; r.fea = fea; r.wr = wr; r.rd = rd;
        exp_q.push_back(r);
        seen = 0;
        for (int k = 1; k <= n + 20 && !seen; k++) begin
            @(negedge clk);
            start[i] = pulses && (k == 10 || k == 50);
            mode[i] = start[i] ? 2'b11 : m;
            rd_only[i] = start[i] ? 1'b1 : ro;
            if (done[i]) seen = 1;
        end
        start[i] = 1'b0;
        rd_only[i] = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; mode[i] = 2'b00; rd_only[i] = 1'b0;
            wr_cnt[i] = 0; rd_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i, "reset");
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // Fault-free incrementing pattern.
        do_run(0, 2'b00, 1'b0, 97, 1, 0, 0, 0, 32, 64, 0);

        // Checkerboard with a stuck bit at address 6.
        stuck_en = 1'b1;
        do_run(0, 2'b01, 1'b0, 97, 0, 1, 1, 6, 32, 64, 0);
        stuck_en = 1'b0;

        // Extra start pulses mid-run must not restart or relatch.
        do_run(0, 2'b00, 1'b0, 97, 1, 0, 0, 0, 32, 64, 1);
        repeat (20) @(negedge clk);
        chk("no_restart_busy", int'(busy[0]), 0);

        // Reset during the read slot of address 12, then a clean rerun.
        begin
            bit hit;
            @(negedge clk);
            start[0] = 1'b1; mode[0] = 2'b10;
            @(negedge clk);
            start[0] = 1'b0;
            hit = 0;
            for (int k = 0; k < 200 && !hit; k++) begin
                if (mem_read[0] && mem_addr[0] == 5'd12) hit = 1;
                else @(negedge clk);
            end
            chk("reach_addr12", int'(hit), 1);
            rst_n[0] = 1'b0;
            @(negedge clk);
            check_zero(0, "midrun_reset");
            rst_n[0] = 1'b1;
        end
        do_run(0, 2'b00, 1'b0, 97, 1, 0, 0, 0, 32, 64, 0);

        // Longer read latency with inverted pattern.
        do_run(1, 2'b10, 1'b0, 161, 1, 0, 0, 0, 32, 128, 0);

        // Read-only against blank memory, saturating 4-bit error counter.
        do_run(2, 2'b11, 1'b1, 65, 0, 15, 1, 0, 0, 64, 0);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
